// File: rtl/bsg_cycle_meter_pkg.sv
// Shared types and helpers for the cycle interval meter.
package bsg_cycle_meter_pkg;

    // Default counter width used when the meter is instantiated without overrides
    localparam int default_width_lp = 16;

    // Measurement state
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } meter_state_e;

    // Width of a pointer that can address els entries, never less than one bit
    function automatic int ptr_width(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bsg_cycle_meter_fifo.sv
// In-order result buffer with valid/yumi handshake and asynchronous active-low reset.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module bsg_cycle_meter_fifo
    import bsg_cycle_meter_pkg::*;
#(
    parameter int width_p = 17,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    input  logic               yumi_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);

    localparam int ptr_w_lp = ptr_width(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic [ptr_w_lp-1:0] wr_ptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                empty;
    logic                push;
    logic                pop;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy flags and the accepted push/pop strobes
    always_comb begin
        empty  = (cnt_r == '0);
        full_o = (cnt_r == cnt_w_lp'(els_p));
        pop    = yumi_i & ~empty;
        push   = v_i & (~full_o | pop);
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Read/write pointers and occupancy count
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + cnt_w_lp'(1);
                2'b01:   cnt_r <= cnt_r - cnt_w_lp'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Head entry, forced to zero when nothing is buffered
    always_comb begin
        v_o    = ~empty;
        data_o = empty ? '0 : mem_r[rd_ptr_r];
    end

endmodule

// File: rtl/bsg_cycle_interval_meter.sv
// Samples a free-running counter on start/stop events and queues the modular
// elapsed count together with a full-lap overflow flag.
module bsg_cycle_interval_meter
    import bsg_cycle_meter_pkg::*;
#(
    parameter int width_p = default_width_lp,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] ctr_i,
    input  logic               start_v_i,
    input  logic               stop_v_i,
    output logic               v_o,
    output logic [width_p-1:0] delta_o,
    output logic               overflow_o,
    input  logic               yumi_i,
    output logic               armed_o,
    output logic               drop_o
);

    typedef struct packed {
        logic               overflow;
        logic [width_p-1:0] delta;
    } result_s;

    meter_state_e       state_r;
    logic [width_p-1:0] start_r;
    logic               lap_r;
    logic               drop_r;
    logic               push_v;
    logic               fifo_full;
    logic               fifo_v;
    result_s            push_data;
    result_s            head;

    // Result of the interval closing this cycle; lap_r is the pre-update value
    always_comb begin
        push_v             = (state_r == ARMED) & stop_v_i;
        push_data.delta    = ctr_i - start_r;
        push_data.overflow = lap_r;
    end

    bsg_cycle_meter_fifo #(
        .width_p($bits(result_s)),
        .els_p  (els_p)
    ) fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (push_data),
        .v_i      (push_v),
        .yumi_i   (yumi_i),
        .v_o      (fifo_v),
        .data_o   (head),
        .full_o   (fifo_full)
    );

    // Measurement FSM with start sample and lap detection
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            start_r <= '0;
            lap_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_v_i) begin
                        start_r <= ctr_i;
                        lap_r   <= 1'b0;
                        state_r <= ARMED;
                    end
                end
                ARMED: begin
                    // A start (with or without stop) re-arms on this cycle's sample
                    if (start_v_i) begin
                        start_r <= ctr_i;
                        lap_r   <= 1'b0;
                    end else if (stop_v_i) begin
                        state_r <= IDLE;
                    end else if (ctr_i == start_r) begin
                        lap_r <= 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Sticky flag for a result lost to a full buffer with no same-cycle pop
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_r <= 1'b0;
        end else if (push_v & fifo_full & ~yumi_i) begin
            drop_r <= 1'b1;
        end
    end

    // Outputs come straight from registers or the buffer head
    always_comb begin
        v_o        = fifo_v;
        delta_o    = head.delta;
        overflow_o = head.overflow;
        armed_o    = (state_r == ARMED);
        drop_o     = drop_r;
    end

endmodule

// File: tb/tb_bsg_cycle_interval_meter.sv
// Randomized and directed bench for bsg_cycle_interval_meter against a
// behavioural model based on elapsed cycle counts and a result queue.
module tb_bsg_cycle_interval_meter;

    localparam int W   = 16;
    localparam int ELS = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] ctr;
    logic         start_v, stop_v, yumi;
    logic         v_o, overflow_o, armed_o, drop_o;
    logic [W-1:0] delta_o;

    int compared   = 0;
    int mismatched = 0;

    bsg_cycle_interval_meter #(.width_p(W), .els_p(ELS)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .ctr_i     (ctr),
        .start_v_i (start_v),
        .stop_v_i  (stop_v),
        .v_o       (v_o),
        .delta_o   (delta_o),
        .overflow_o(overflow_o),
        .yumi_i    (yumi),
        .armed_o   (armed_o),
        .drop_o    (drop_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic         ovf;
        logic [W-1:0] d;
    } res_t;

    res_t         q[$];
    logic         m_armed;
    logic         m_drop;
    logic [W-1:0] m_start;
    longint       m_t;
    longint       cyc_n;

    // Overflow means more than one full counter period elapsed; a stop exactly
    // one period later sees the start value on the stop cycle itself, which is not a lap.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_armed = 1'b0;
            m_drop  = 1'b0;
            m_start = '0;
            m_t     = 0;
            cyc_n   = 0;
        end else begin
            bit   pop;
            res_t r;
            cyc_n = cyc_n + 1;
            pop = yumi && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (m_armed && stop_v) begin
                r.d   = ctr - m_start;
                r.ovf = ((cyc_n - m_t) > 65536);
                if (q.size() < ELS) q.push_back(r);
                else m_drop = 1'b1;
            end
            if (start_v) begin
                m_armed = 1'b1;
                m_start = ctr;
                m_t     = cyc_n;
            end else if (stop_v) begin
                m_armed = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        bit hv;
        hv = (q.size() > 0);
        check("v_o", 32'(v_o), 32'(hv));
        check("delta_o", 32'(delta_o), hv ? 32'(q[0].d) : 32'd0);
        check("overflow_o", 32'(overflow_o), hv ? 32'(q[0].ovf) : 32'd0);
        check("armed_o", 32'(armed_o), 32'(m_armed));
        check("drop_o", 32'(drop_o), 32'(m_drop));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic s, input logic p, input logic y);
        @(negedge clk);
        ctr     = ctr + 1'b1;
        start_v = s;
        stop_v  = p;
        yumi    = y && (q.size() > 0);
    endtask

    // Next step presents value v on ctr (only used while no measurement is open)
    task automatic jump(input logic [W-1:0] v);
        ctr = v - 1'b1;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic interval(input int len, input logic y_at_stop);
        step(1'b1, 1'b0, 1'b0);
        repeat (len - 1) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, y_at_stop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        ctr     = '0;
        start_v = 1'b0;
        stop_v  = 1'b0;
        yumi    = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        settle();
        check("rst v_o", 32'(v_o), 32'd0);
        check("rst delta_o", 32'(delta_o), 32'd0);
        check("rst overflow_o", 32'(overflow_o), 32'd0);
        check("rst armed_o", 32'(armed_o), 32'd0);
        check("rst drop_o", 32'(drop_o), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Basic 100 -> 150
        jump(16'd100);
        step(1'b1, 1'b0, 1'b0);
        repeat (49) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        settle();
        check("basic v_o", 32'(v_o), 32'd1);
        check("basic delta", 32'(delta_o), 32'd50);
        check("basic ovf", 32'(overflow_o), 32'd0);
        check("basic armed", 32'(armed_o), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        settle();
        check("basic popped", 32'(v_o), 32'd0);

        // Wrap 0xFFF0 -> 0x0010
        jump(16'hFFF0);
        step(1'b1, 1'b0, 1'b0);
        repeat (31) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        settle();
        check("wrap delta", 32'(delta_o), 32'h20);
        check("wrap ovf", 32'(overflow_o), 32'd0);
        step(1'b0, 1'b0, 1'b1);

        // Full lap: start at 5, stop 65539 cycles later at 8
        jump(16'd5);
        step(1'b1, 1'b0, 1'b0);
        repeat (65538) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        settle();
        check("lap delta", 32'(delta_o), 32'd3);
        check("lap ovf", 32'(overflow_o), 32'd1);
        step(1'b0, 1'b0, 1'b1);

        // Buffer full: 10, 20 fill; 7 closes with a pop (accepted); 30 is lost
        interval(10, 1'b0);
        interval(20, 1'b0);
        settle();
        check("full head10", 32'(delta_o), 32'd10);
        check("full nodrop", 32'(drop_o), 32'd0);
        interval(7, 1'b1);
        settle();
        check("full+pop nodrop", 32'(drop_o), 32'd0);
        check("full+pop head20", 32'(delta_o), 32'd20);
        interval(30, 1'b0);
        settle();
        check("full drop", 32'(drop_o), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        settle();
        check("full head7", 32'(delta_o), 32'd7);
        step(1'b0, 1'b0, 1'b1);
        settle();
        check("full empty", 32'(v_o), 32'd0);

        // Back-to-back: start 10, start+stop 30, stop 35
        jump(16'd10);
        step(1'b1, 1'b0, 1'b0);
        repeat (19) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        settle();
        check("b2b armed mid", 32'(armed_o), 32'd1);
        check("b2b first", 32'(delta_o), 32'd20);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        settle();
        check("b2b armed end", 32'(armed_o), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        settle();
        check("b2b second", 32'(delta_o), 32'd5);
        step(1'b0, 1'b0, 1'b1);

        // Stray stop in IDLE, then restart while ARMED at 40, stop at 45
        step(1'b0, 1'b1, 1'b0);
        settle();
        check("stray v_o", 32'(v_o), 32'd0);
        jump(16'd30);
        step(1'b1, 1'b0, 1'b0);
        repeat (9) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        settle();
        check("restart delta", 32'(delta_o), 32'd5);
        step(1'b0, 1'b0, 1'b1);

        // Reset mid-operation: one buffered result, armed, drop set earlier
        interval(12, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst v_o", 32'(v_o), 32'd0);
        check("midrst delta", 32'(delta_o), 32'd0);
        check("midrst armed", 32'(armed_o), 32'd0);
        check("midrst drop", 32'(drop_o), 32'd0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        settle();
        check("post-rst stop", 32'(v_o), 32'd0);

        // Randomized traffic
        repeat (4000) begin
            if (!m_armed && ($urandom_range(0, 63) == 0)) jump(W'($urandom));
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1));
        end
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
